logic_shift_rotate_top: RTL and testbench
=========================================

# logic_shift_rotate_top

Single-position shift/rotate unit of the 4-bit ALSU. It selects operand A or B and applies a 1-bit logical shift or rotate, left or right, under a 3-bit select. The combinational result feeds the ALSU output mux. A registered copy is also provided for pipelined consumers on the ALSU clock.

## Interface
- WIDTH, 4: operand and result width; must be ≥ 2.
- clk  input  1  rising-edge clock; used only by the registered result.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Sel  input  3  operation select (see Operation).
- Out  output  WIDTH  combinational result.
- Out_q  output  WIDTH  Out registered on clk.

## Operation
- Sel decode:
  - Sel[2]: 0 = logical shift, 1 = rotate.
  - Sel[1]: 0 = operand A, 1 = operand B.
  - Sel[0]: 0 = right, 1 = left.
- Opcode table:
  - 000 = A >> 1
  - 001 = A << 1
  - 010 = B >> 1
  - 011 = B << 1
  - 100 = rotate A right
  - 101 = rotate A left
  - 110 = rotate B right
  - 111 = rotate B left
- Shift amount is always exactly 1.
- Logical shift right: Out = {1'b0, X[WIDTH-1:1]}. The LSB is discarded and the MSB is zero-filled.
- Logical shift left: Out = {X[WIDTH-2:0], 1'b0}. The MSB is discarded, no carry or overflow flag is produced, and the LSB is zero-filled.
- Rotate right: Out = {X[0], X[WIDTH-1:1]}.
- Rotate left: Out = {X[WIDTH-2:0], X[WIDTH-1]}.
- The non-selected operand has no effect on either output.
- All 8 Sel codes are defined, so there is no default or illegal case.
- X or Z on any used input bit propagates to Out. No masking is done.

## Timing
- Out is purely combinational from A, B and Sel: zero-cycle latency, no dependence on clk or rst_n.
- Out_q captures Out on every rising clk edge: one-cycle latency, no enable, no handshake.
- rst_n low forces Out_q = 0 immediately (asynchronous) and holds it at 0 while low.
- The first capture occurs on the first rising clk edge after rst_n deasserts.
- Reset never affects Out.
- Inputs changing mid-cycle: Out follows immediately; Out_q reflects the value present at the next edge.

## Structure
- Shared package (alsu_pkg):
  - Sel field positions: SEL_ROT = 2, SEL_OPB = 1, SEL_LEFT = 0.
  - The 8 opcode localparams.
  - Default WIDTH.
- One sub-module, shift_rotate_1 (WIDTH parameter):
  - Inputs: X, left, rotate.
  - Output: Y.
  - Implements the four single-bit transforms.
- Top level:
  - Operand mux on Sel[1].
  - Instance of shift_rotate_1.
  - Output register with asynchronous reset.

## Test plan
- Shifts, A = 1001, B = 0000:
  - Sel 000 -> Out 0100.
  - Sel 001 -> Out 0010.
  - A = 1000, Sel 001 -> 0000 (MSB lost).
- B path with A = 0000:
  - B = 0111, Sel 010 -> 0011.
  - Sel 011 -> 1110.
  - Sel 110 -> 1011.
  - Sel 111 -> 1110.
  - Repeat with A = 1111; results must be unchanged.
- Rotates, A = 0011:
  - Sel 100 -> 1001.
  - Sel 101 -> 0110.
  - A = 1111, both rotate directions -> 1111.
  - A = 1000, Sel 101 -> 0001.
- Exhaustive sweep: all 16×16×8 combinations of A, B, Sel checked against the reference formulas. Out is sampled after settling; Out_q is checked one clk later.
- Reset:
  - Drive A = 1100, Sel 100 and clock so Out_q = 0110.
  - Assert rst_n between edges -> Out_q = 0 immediately, while Out stays 0110.
  - Release rst_n -> next edge gives Out_q = 0110.

Source files
------------

// File: rtl/alsu_pkg.sv
// -----------------------------------------------------------------------------
// alsu_pkg
// Shared definitions for the 4-bit ALSU shift/rotate path.
//   DEFAULT_WIDTH : default operand/result width
//   SEL_ROT/SEL_OPB/SEL_LEFT : bit positions of the fields inside the 3-bit Sel
//   OP_* : the eight shift/rotate opcodes (every 3-bit code is legal)
// -----------------------------------------------------------------------------
package alsu_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Sel field positions
    localparam int SEL_ROT  = 2;   // 0 = logical shift, 1 = rotate
    localparam int SEL_OPB  = 1;   // 0 = operand A,     1 = operand B
    localparam int SEL_LEFT = 0;   // 0 = right,         1 = left

    typedef logic [2:0] sel_t;

    // Opcode table
    localparam sel_t OP_SHR_A = 3'b000;
    localparam sel_t OP_SHL_A = 3'b001;
    localparam sel_t OP_SHR_B = 3'b010;
    localparam sel_t OP_SHL_B = 3'b011;
    localparam sel_t OP_ROR_A = 3'b100;
    localparam sel_t OP_ROL_A = 3'b101;
    localparam sel_t OP_ROR_B = 3'b110;
    localparam sel_t OP_ROL_B = 3'b111;

endpackage

// File: rtl/shift_rotate_1.sv
// -----------------------------------------------------------------------------
// shift_rotate_1
// Single-position logical shift or rotate of one operand.
//   X      : operand (WIDTH bits, WIDTH >= 2)
//   left   : 1 = move towards MSB, 0 = move towards LSB
//   rotate : 1 = wrap the bit falling off into the vacated end, 0 = zero-fill
//   Y      : transformed operand
// Ternaries are used rather than if/else so that an unknown on left or rotate
// shows up as unknown on Y instead of silently choosing one branch.
// -----------------------------------------------------------------------------
module shift_rotate_1
    import alsu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] X,
    input  logic             left,
    input  logic             rotate,
    output logic [WIDTH-1:0] Y
);

    logic             fill_left_s;   // bit entering at the LSB on a left move
    logic             fill_right_s;  // bit entering at the MSB on a right move
    logic [WIDTH-1:0] left_s;
    logic [WIDTH-1:0] right_s;

    assign fill_left_s  = rotate ? X[WIDTH-1] : 1'b0;
    assign fill_right_s = rotate ? X[0]       : 1'b0;

    assign left_s  = {X[WIDTH-2:0], fill_left_s};
    assign right_s = {fill_right_s, X[WIDTH-1:1]};

    assign Y = left ? left_s : right_s;

endmodule

// File: rtl/logic_shift_rotate_top.sv
// -----------------------------------------------------------------------------
// logic_shift_rotate_top
// Shift/rotate unit of the ALSU: picks A or B, shifts or rotates it by one
// position, and provides both the combinational result and a registered copy.
//   clk   : rising-edge clock, only used by Out_q
//   rst_n : asynchronous active-low reset, clears Out_q only
//   A, B  : operands (WIDTH bits)
//   Sel   : {rotate, use_B, left}
//   Out   : combinational result, independent of clk/rst_n
//   Out_q : Out captured on every rising clk edge
// -----------------------------------------------------------------------------
module logic_shift_rotate_top
    import alsu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Sel,
    output logic [WIDTH-1:0] Out,
    output logic [WIDTH-1:0] Out_q
);

    logic [WIDTH-1:0] operand_s;
    logic [WIDTH-1:0] result_s;
    logic [WIDTH-1:0] out_q_r;

    // Operand select; the other operand never reaches the datapath.
    assign operand_s = Sel[SEL_OPB] ? B : A;

    shift_rotate_1 #(
        .WIDTH (WIDTH)
    ) u_shift_rotate_1 (
        .X      (operand_s),
        .left   (Sel[SEL_LEFT]),
        .rotate (Sel[SEL_ROT]),
        .Y      (result_s)
    );

    assign Out = result_s;

    // Pipelined copy of the result for consumers on the ALSU clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q_r <= {WIDTH{1'b0}};
        end else begin
            out_q_r <= result_s;
        end
    end

    assign Out_q = out_q_r;

endmodule

// File: tb/tb_logic_shift_rotate_top.sv
// -----------------------------------------------------------------------------
// tb_logic_shift_rotate_top
// Self-checking bench: directed cases, exhaustive sweep, random mid-cycle
// changes and reset behaviour, all compared against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_logic_shift_rotate_top;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
    logic [W-1:0] out_s;
    logic [W-1:0] out_q_s;

    int total;
    int bad;

    logic_shift_rotate_top #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a),
        .B     (b),
        .Sel   (sel),
        .Out   (out_s),
        .Out_q (out_q_s)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: integer arithmetic straight from the opcode meaning.
    function automatic logic [W-1:0] model(input int av, input int bv, input int sv);
        int x;
        int r;
        int top;
        top = 1 << (W - 1);
        x = ((sv / 2) % 2 == 1) ? bv : av;
        if (sv >= 4) begin
            if (sv % 2 == 1) r = ((x * 2) % (2 * top)) + (x / top);
            else             r = (x / 2) + ((x % 2) * top);
        end else begin
            if (sv % 2 == 1) r = (x * 2) % (2 * top);
            else             r = x / 2;
        end
        return r[W-1:0];
    endfunction

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Directed vector: Out checked against a hand-written constant, then Out_q.
    task automatic dir_vec(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [2:0] sv, input logic [W-1:0] exp);
        @(posedge clk); #1;
        a = av; b = bv; sel = sv;
        #1;
        check_val({tag, "_out"}, out_s, exp);
        @(posedge clk); #1;
        check_val({tag, "_outq"}, out_q_s, exp);
    endtask

    logic [W-1:0] exp_v;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        a = 4'b0000; b = 4'b0000; sel = 3'b000;

        // Reset state
        #2;
        check_val("reset_outq", out_q_s, 4'b0000);
        @(posedge clk); #1;
        check_val("reset_hold_outq", out_q_s, 4'b0000);
        #2 rst_n = 1'b1;

        // Shifts on A
        dir_vec("shr_a",     4'b1001, 4'b0000, 3'b000, 4'b0100);
        dir_vec("shl_a",     4'b1001, 4'b0000, 3'b001, 4'b0010);
        dir_vec("shl_a_msb", 4'b1000, 4'b0000, 3'b001, 4'b0000);

        // B path, A irrelevant
        for (int k = 0; k < 2; k++) begin
            logic [W-1:0] av;
            av = (k == 0) ? 4'b0000 : 4'b1111;
            dir_vec("shr_b", av, 4'b0111, 3'b010, 4'b0011);
            dir_vec("shl_b", av, 4'b0111, 3'b011, 4'b1110);
            dir_vec("ror_b", av, 4'b0111, 3'b110, 4'b1011);
            dir_vec("rol_b", av, 4'b0111, 3'b111, 4'b1110);
        end

        // Rotates on A
        dir_vec("ror_a",      4'b0011, 4'b0000, 3'b100, 4'b1001);
        dir_vec("rol_a",      4'b0011, 4'b0000, 3'b101, 4'b0110);
        dir_vec("ror_a_ones", 4'b1111, 4'b0000, 3'b100, 4'b1111);
        dir_vec("rol_a_ones", 4'b1111, 4'b0000, 3'b101, 4'b1111);
        dir_vec("rol_a_msb",  4'b1000, 4'b0000, 3'b101, 4'b0001);

        // Exhaustive sweep
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int is = 0; is < 8; is++) begin
                    @(posedge clk); #1;
                    a = ia[W-1:0]; b = ib[W-1:0]; sel = is[2:0];
                    exp_v = model(ia, ib, is);
                    #1;
                    check_val("sweep_out", out_s, exp_v);
                    @(posedge clk); #1;
                    check_val("sweep_outq", out_q_s, exp_v);
                end
            end
        end

        // Random with a mid-cycle input change: Out_q must track the last value
        for (int n = 0; n < 200; n++) begin
            int ra, rb, rs;
            @(posedge clk); #1;
            ra = int'($urandom_range(15)); rb = int'($urandom_range(15)); rs = int'($urandom_range(7));
            a = ra[W-1:0]; b = rb[W-1:0]; sel = rs[2:0];
            #1;
            check_val("rand_out1", out_s, model(ra, rb, rs));
            ra = int'($urandom_range(15)); rb = int'($urandom_range(15)); rs = int'($urandom_range(7));
            a = ra[W-1:0]; b = rb[W-1:0]; sel = rs[2:0];
            exp_v = model(ra, rb, rs);
            #1;
            check_val("rand_out2", out_s, exp_v);
            @(posedge clk); #1;
            check_val("rand_outq", out_q_s, exp_v);
        end

        // Asynchronous reset in the middle of a cycle
        @(posedge clk); #1;
        a = 4'b1100; b = 4'b0000; sel = 3'b100;
        @(posedge clk); #1;
        check_val("rst_pre_outq", out_q_s, 4'b0110);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_async_outq", out_q_s, 4'b0000);
        check_val("rst_async_out", out_s, 4'b0110);
        @(posedge clk); #1;
        check_val("rst_held_outq", out_q_s, 4'b0000);
        check_val("rst_held_out", out_s, 4'b0110);
        #2 rst_n = 1'b1;
        #1;
        check_val("rst_rel_outq", out_q_s, 4'b0000);
        @(posedge clk); #1;
        check_val("rst_first_cap", out_q_s, 4'b0110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
